reg_unpacker: RTL and testbench

REG_UNPACKER -- requirements
Module: reg_unpacker

---
 rtl/reg_unpacker.sv | 77 +++++++
 tb/tb_reg_unpacker.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/reg_unpacker.sv
// Word-to-slice unpacker: accepts a WIDTH-bit word and emits it LSB-first as NUM CHUNK-bit slices.
// Optional o_last marker port is built when REG_UNPACK_LAST_EN is defined.
module reg_unpacker #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data_in,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [CHUNK-1:0] o_data_out,
  output logic             o_valid,
  input  logic             i_ready,
`ifdef REG_UNPACK_LAST_EN
  output logic             o_last,
`endif
  output logic             o_busy
);

  localparam int NUM   = WIDTH / CHUNK;
  localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   idx, idx_nx;
  logic [WIDTH-1:0]   shreg, shreg_nx;
  logic               at_last, accept, xfer;

  assign at_last    = (idx == LAST_IDX);
  assign o_valid    = (state == SHIFT);
  assign o_busy     = (state == SHIFT);
  // Final slice leaving frees the register, so a new word can land on the same edge.
  assign o_ready    = (state == IDLE) || (at_last && i_ready);
  assign o_data_out = shreg[CHUNK-1:0];
  assign accept     = i_valid && o_ready;
  assign xfer       = o_valid && i_ready;

`ifdef REG_UNPACK_LAST_EN
  assign o_last     = o_valid && at_last;
`endif

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    shreg_nx = shreg;
    if (accept) begin
      shreg_nx = i_data_in;
      idx_nx   = '0;
      state_nx = SHIFT;
    end else if (xfer) begin
      // Shifting on the final slice too leaves the register zeroed when idle.
      shreg_nx = shreg >> CHUNK;
      if (at_last) begin
        idx_nx   = '0;
        state_nx = IDLE;
      end else begin
        idx_nx   = idx + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      shreg <= shreg_nx;
    end
  end

endmodule

// File: tb/tb_reg_unpacker.sv
// Directed self-checking bench for reg_unpacker (WIDTH=32, CHUNK=8), o_last checked when REG_UNPACK_LAST_EN is set.
module tb_reg_unpacker;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_data_in;
  logic        i_valid;
  logic        o_ready;
  logic [7:0]  o_data_out;
  logic        o_valid;
  logic        i_ready;
  logic        o_busy;
  logic        last_obs;
`ifdef REG_UNPACK_LAST_EN
  logic        o_last;
  assign last_obs = o_last;
`else
  assign last_obs = 1'b0;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  reg_unpacker #(.WIDTH(32), .CHUNK(8)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_data_in  (i_data_in),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_data_out (o_data_out),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
`ifdef REG_UNPACK_LAST_EN
    .o_last     (o_last),
`endif
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  // Present a word while idle and let the accept edge pass.
  task automatic accept_word(input logic [31:0] w, input string tag);
    i_data_in = w;
    i_valid   = 1'b1;
    #1;
    chk({tag, "_acc_ready"}, o_ready, 1'b1);
    cyc();
    i_valid = 1'b0;
  endtask

  // Drain four slices with i_ready high, checking data, o_ready and o_last.
  task automatic drain(input logic [7:0] e0, e1, e2, e3, input string tag);
    logic [7:0] e [4];
    e = '{e0, e1, e2, e3};
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("%s_valid%0d", tag, k), o_valid, 1'b1);
      chk($sformatf("%s_data%0d", tag, k), o_data_out, e[k]);
      chk($sformatf("%s_ready%0d", tag, k), o_ready, (k == 3));
      chk($sformatf("%s_busy%0d", tag, k), o_busy, 1'b1);
`ifdef REG_UNPACK_LAST_EN
      chk($sformatf("%s_last%0d", tag, k), last_obs, (k == 3));
`endif
      cyc();
    end
    #1;
    chk({tag, "_done_valid"}, o_valid, 1'b0);
    chk({tag, "_done_busy"}, o_busy, 1'b0);
  endtask

  initial begin
    logic [7:0] st_data [6];
    logic       st_rdy  [6];
    logic [7:0] b2b     [8];

    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_data_in = 32'h0;
    cyc(); cyc();
    i_rst = 1'b0;
    #1;
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_busy",  o_busy, 1'b0);
    chk("rst_data",  o_data_out, 8'h00);
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_last",  last_obs, 1'b0);
    cyc();

    // Basic unpack with downstream always ready.
    accept_word(32'hA1B2C3D4, "basic");
    drain(8'hD4, 8'hC3, 8'hB2, 8'hA1, "basic");
    cyc();

    // Stalls: ready pattern 1 (accept cycle),0,0,1,1,1 then 1.
    st_data = '{8'hD4, 8'hD4, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
    st_rdy  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    i_ready = 1'b1;
    accept_word(32'hA1B2C3D4, "stall");
    for (int k = 0; k < 6; k++) begin
      i_ready = st_rdy[k];
      #1;
      chk($sformatf("stall_valid%0d", k), o_valid, 1'b1);
      chk($sformatf("stall_data%0d", k), o_data_out, st_data[k]);
`ifdef REG_UNPACK_LAST_EN
      chk($sformatf("stall_last%0d", k), last_obs, (k == 5));
`endif
      cyc();
    end
    #1;
    chk("stall_done_valid", o_valid, 1'b0);
    cyc();

    // Back-to-back words, no gap between them.
    b2b = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
    i_ready = 1'b1;
    accept_word(32'h11223344, "b2b");
    i_valid   = 1'b1;
    i_data_in = 32'h55667788;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("b2b_valid%0d", k), o_valid, 1'b1);
      chk($sformatf("b2b_data%0d", k), o_data_out, b2b[k]);
      chk($sformatf("b2b_ready%0d", k), o_ready, (k == 3 || k == 7));
      cyc();
      if (k == 3) i_valid = 1'b0;
    end
    #1;
    chk("b2b_done_valid", o_valid, 1'b0);
    cyc();

    // Reset while C3 is on the output discards the rest.
    accept_word(32'hA1B2C3D4, "mrst");
    #1; chk("mrst_d4", o_data_out, 8'hD4);
    cyc();
    #1; chk("mrst_c3", o_data_out, 8'hC3);
    i_rst = 1'b1;
    cyc();
    i_rst = 1'b0;
    #1;
    chk("mrst_valid", o_valid, 1'b0);
    chk("mrst_busy",  o_busy, 1'b0);
    chk("mrst_ready", o_ready, 1'b1);
    chk("mrst_data",  o_data_out, 8'h00);
    cyc();
    cyc();
    #1; chk("mrst_hold_valid", o_valid, 1'b0);
    accept_word(32'h000000FF, "post");
    drain(8'hFF, 8'h00, 8'h00, 8'h00, "post");

    // Input changes after accept must not leak into in-flight slices.
    accept_word(32'h01020304, "samp");
    i_data_in = 32'hDEADBEEF;
    drain(8'h04, 8'h03, 8'h02, 8'h01, "samp");

    // Reset beats a same-edge accept.
    i_rst = 1'b1; i_valid = 1'b1; i_data_in = 32'h12345678;
    cyc();
    i_rst = 1'b0; i_valid = 1'b0;
    #1;
    chk("rstpri_valid", o_valid, 1'b0);
    chk("rstpri_busy",  o_busy, 1'b0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
